// File: rtl/ped_track_if.sv
// ped_track_if: sample stream and pedestal control bundle.
// The master side drives the ADC samples and controls; the slave side returns the results.
interface ped_track_if #(
    parameter int ABITS = 12
);
    logic [ABITS-1:0] adc_data;
    logic             invert;
    logic             start;
    logic [ABITS-1:0] reject_thr;
    logic [15:0]      data;
    logic [ABITS-1:0] ped;
    logic             ped_valid;
    logic             busy;
    logic             done;
    logic [7:0]       reject_cnt;

    modport master (
        output adc_data, invert, start, reject_thr,
        input  data, ped, ped_valid, busy, done, reject_cnt
    );

    modport slave (
        input  adc_data, invert, start, reject_thr,
        output data, ped, ped_valid, busy, done, reject_cnt
    );
endinterface

// File: rtl/ped_track.sv
// ped_track: measures the pedestal by averaging 2^AVGLOG samples and outputs baseline-subtracted samples.
// Defining PED_AUTO_EN adds an internal start every PERIOD cycles.
module ped_track #(
    parameter int          ABITS  = 12,
    parameter int          AVGLOG = 4,
    parameter logic [15:0] PERIOD = 16'd50000
) (
    input  logic      adcclk,
    input  logic      reset,
    ped_track_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    localparam int AW = ABITS + AVGLOG;
    localparam logic [AVGLOG-1:0] CNT_ONE = 1;

    state_t            state_q;
    logic [AW-1:0]     acc_q;
    logic [AVGLOG-1:0] cnt_q;
    logic [ABITS-1:0]  ped_q;
    logic              ped_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        rej_q;
    logic [ABITS-1:0]  adc_q;
    logic [15:0]       data_q;
    logic [15:0]       data_d;
    logic [ABITS:0]    sub;
    logic [ABITS-1:0]  absd;
    logic [AW-1:0]     adc_ext;
    logic              auto_start;
    logic              start_any;

`ifdef PED_AUTO_EN
    logic [15:0] per_q;

    // Free-running period counter; fires once every PERIOD cycles
    always_ff @(posedge adcclk) begin
        if (reset || auto_start) per_q <= 16'd0;
        else                     per_q <= per_q + 16'd1;
    end

    assign auto_start = (per_q == PERIOD - 16'd1);
`else
    // PERIOD has no effect when automatic starts are not built in
    assign auto_start = (PERIOD == 16'd0) & 1'b0;
`endif

    assign start_any = bus.start | auto_start;
    assign adc_ext   = {{AVGLOG{1'b0}}, bus.adc_data};
    assign absd      = (bus.adc_data >= ped_q) ? bus.adc_data - ped_q
                                               : ped_q - bus.adc_data;

    // Measurement FSM: accumulate, reject outliers, then load the pedestal
    always_ff @(posedge adcclk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ped_q       <= '0;
            ped_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rej_q       <= 8'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_any) begin
                        state_q <= ACCUM;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ACCUM: begin
                    if (ped_valid_q && (absd > bus.reject_thr)) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
                    end else begin
                        acc_q <= acc_q + adc_ext;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (&cnt_q) state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    ped_q       <= acc_q[AW-1:AVGLOG];
                    ped_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Signed difference against the current pedestal, direction chosen by invert
    always_comb begin
        sub = '0;
        if (bus.invert) sub = {1'b0, ped_q} - {1'b0, adc_q};
        else            sub = {1'b0, adc_q} - {1'b0, ped_q};
        data_d = {{(15 - ABITS){sub[ABITS]}}, sub};
    end

    // Two-stage sample path: capture the ADC word, then register the difference
    always_ff @(posedge adcclk) begin
        if (reset) begin
            adc_q  <= '0;
            data_q <= 16'd0;
        end else begin
            adc_q  <= bus.adc_data;
            data_q <= data_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.ped        = ped_q;
    assign bus.ped_valid  = ped_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.reject_cnt = rej_q;
endmodule
